// File: rtl/branch_ctrl.sv
// EX-stage branch controller: waits for forwarded operands, resolves branches/jumps,
// issues a registered one-cycle PC redirect + flush, and keeps saturating branch statistics.
module branch_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   input  logic [1:0]       op,
   input  logic [2:0]       funct3,
   input  logic             opnd_rdy,
   input  logic             BrEq,
   input  logic             BrLt,
   output logic             BrUn,
   output logic             stall,
   output logic             pc_sel,
   output logic             flush,
   output logic             br_err,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_BR   = 2'b01;
   localparam logic [1:0] OP_JAL  = 2'b10;

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_WAIT     = 2'b01,
      S_REDIRECT = 2'b10
   } state_t;

   state_t state, state_nxt;

   logic req;
   logic need_opnd;
   logic is_br;
   logic lt_m;
   logic cond_taken;
   logic cond_err;
   logic resolve;
   logic taken;

   assign BrUn = funct3[1];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   // Next state, stall and resolution decode
   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      resolve    = 1'b0;
      taken      = 1'b0;
      cond_taken = 1'b0;
      cond_err   = 1'b0;

      req       = br_valid && (op != OP_NONE);
      need_opnd = (op != OP_JAL);
      is_br     = (op == OP_BR);
      // BrLt is only meaningful when the operands differ; masking keeps an X out of the result
      lt_m      = BrLt & ~BrEq;

      case (funct3)
         3'b000:  cond_taken = BrEq;
         3'b001:  cond_taken = ~BrEq;
         3'b100,
         3'b110:  cond_taken = lt_m;
         3'b101,
         3'b111:  cond_taken = ~lt_m;
         default: cond_err   = 1'b1;
      endcase

      case (state)
         S_RUN, S_WAIT: begin
            if (!req) begin
               state_nxt = S_RUN;
            end else if (need_opnd && !opnd_rdy) begin
               stall     = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               resolve   = 1'b1;
               taken     = is_br ? cond_taken : 1'b1;
               state_nxt = taken ? S_REDIRECT : S_RUN;
            end
         end
         S_REDIRECT: state_nxt = S_RUN;
         default:    state_nxt = S_RUN;
      endcase

      if (rst) stall = 1'b0;
   end

   // Registered redirect, error pulse and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_sel     <= 1'b0;
         flush      <= 1'b0;
         br_err     <= 1'b0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         pc_sel <= resolve && taken;
         flush  <= resolve && taken;
         br_err <= resolve && is_br && cond_err;
         if (resolve && is_br && (branch_cnt != {CNT_W{1'b1}}))
            branch_cnt <= branch_cnt + CNT_W'(1);
         if (resolve && is_br && taken && (taken_cnt != {CNT_W{1'b1}}))
            taken_cnt <= taken_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed test-plan scenarios then random traffic,
// all checked against an operand-level reference model.
module tb_branch_ctrl;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, br_valid, opnd_rdy, BrEq, BrLt;
   logic [1:0]       op;
   logic [2:0]       funct3;
   logic             BrUn, stall, pc_sel, flush, br_err;
   logic [CNT_W-1:0] branch_cnt, taken_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic m_known = 1'b0;
   logic m_redir = 1'b0;
   logic m_err   = 1'b0;
   int   m_bcnt  = 0;
   int   m_tcnt  = 0;

   logic last_stall;
   int   stall_seen;

   branch_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .op(op), .funct3(funct3),
      .opnd_rdy(opnd_rdy), .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn), .stall(stall),
      .pc_sel(pc_sel), .flush(flush), .br_err(br_err),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic br_taken(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: drive after the edge, check at the falling edge, advance the model.
   task automatic cycle(input logic r, input logic v, input logic [1:0] o, input logic [2:0] f,
                        input logic rdy, input logic [7:0] a, input logic [7:0] b);
      logic exp_stall, req, needs, res, tk;
      @(posedge clk);
      #1;
      rst = r; br_valid = v; op = o; funct3 = f; opnd_rdy = rdy;
      BrEq = (a == b);
      BrLt = f[1] ? (a < b) : ($signed(a) < $signed(b));
      if (a == b) BrLt = 1'($urandom_range(0, 1));
      @(negedge clk);

      req       = v && (o != 2'b00);
      needs     = (o != 2'b10);
      exp_stall = !r && !m_redir && req && needs && !rdy;
      last_stall = stall;
      check("stall", 32'(stall), 32'(exp_stall));
      check("BrUn", 32'(BrUn), 32'(f[1]));
      if (m_known) begin
         check("pc_sel", 32'(pc_sel), 32'(m_redir));
         check("flush", 32'(flush), 32'(m_redir));
         check("br_err", 32'(br_err), 32'(m_err));
         check("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
         check("taken_cnt", 32'(taken_cnt), 32'(m_tcnt));
      end

      if (r) begin
         m_known = 1'b1; m_redir = 1'b0; m_err = 1'b0; m_bcnt = 0; m_tcnt = 0;
      end else begin
         res   = !m_redir && req && !(needs && !rdy);
         m_err = 1'b0;
         tk    = 1'b0;
         if (res) begin
            if (o == 2'b01) begin
               tk     = br_taken(f, a, b);
               m_err  = (f == 3'd2) || (f == 3'd3);
               m_bcnt = (m_bcnt < SAT) ? m_bcnt + 1 : m_bcnt;
               if (tk) m_tcnt = (m_tcnt < SAT) ? m_tcnt + 1 : m_tcnt;
            end else begin
               tk = 1'b1;
            end
         end
         m_redir = tk;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 8'd0, 8'd0);
   endtask

   initial begin
      logic       rv, hv;
      logic [1:0] ho;
      logic [2:0] hf;
      logic [7:0] ra, rb;

      // reset, then BEQ taken with BrLt unknown
      cycle(1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 8'd0, 8'd0);
      cycle(1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 8'd0, 8'd0);
      idle(2);
      cycle(1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 8'd7, 8'd7);
      idle(1);
      check("beq_redirect", 32'(pc_sel), 32'd1);
      idle(1);
      check("beq_one_cycle", 32'(pc_sel), 32'd0);
      check("beq_taken_cnt", 32'(taken_cnt), 32'd1);

      // BLTU waiting three cycles for operands
      stall_seen = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 2'b01, 3'b110, 1'b0, 8'd1, 8'd200);
         stall_seen += int'(last_stall);
      end
      cycle(1'b0, 1'b1, 2'b01, 3'b110, 1'b1, 8'd1, 8'd200);
      check("bltu_stall_cycles", 32'(stall_seen), 32'd3);
      idle(2);

      // BGE not taken (signed -1 < 1), JAL without operands
      cycle(1'b0, 1'b1, 2'b01, 3'b101, 1'b1, 8'hff, 8'd1);
      cycle(1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 8'd0, 8'd0);
      idle(2);

      // taken BNE, wrong-path JALR during redirect, then a real JALR
      cycle(1'b0, 1'b1, 2'b01, 3'b001, 1'b1, 8'd3, 8'd4);
      cycle(1'b0, 1'b1, 2'b11, 3'b000, 1'b1, 8'd0, 8'd0);
      cycle(1'b0, 1'b1, 2'b11, 3'b000, 1'b1, 8'd0, 8'd0);
      idle(2);

      // illegal condition codes
      cycle(1'b0, 1'b1, 2'b01, 3'b011, 1'b1, 8'd5, 8'd5);
      cycle(1'b0, 1'b1, 2'b01, 3'b010, 1'b1, 8'd5, 8'd6);
      idle(1);

      // saturate both counters
      for (int i = 0; i < int'(SAT) + 4; i++) begin
         cycle(1'b0, 1'b1, 2'b01, 3'b000, 1'b1, 8'd9, 8'd9);
         idle(1);
      end
      check("sat_branch_cnt", 32'(branch_cnt), 32'(SAT));
      check("sat_taken_cnt", 32'(taken_cnt), 32'(SAT));

      // reset during WAIT, then during REDIRECT
      cycle(1'b0, 1'b1, 2'b01, 3'b100, 1'b0, 8'd1, 8'd2);
      cycle(1'b1, 1'b1, 2'b01, 3'b100, 1'b0, 8'd1, 8'd2);
      idle(2);
      cycle(1'b0, 1'b1, 2'b10, 3'b000, 1'b1, 8'd0, 8'd0);
      cycle(1'b1, 1'b0, 2'b00, 3'b000, 1'b1, 8'd0, 8'd0);
      idle(1);
      check("rst_pc_sel", 32'(pc_sel), 32'd0);
      check("rst_cnt", 32'(branch_cnt), 32'd0);

      // random traffic; a stalled request is held stable by upstream
      hv = 1'b0; ho = 2'b00; hf = 3'b000;
      for (int i = 0; i < 3000; i++) begin
         if (!last_stall) begin
            hv = ($urandom_range(0, 3) != 0);
            ho = 2'($urandom_range(0, 3));
            hf = 3'($urandom_range(0, 7));
         end
         rv = ($urandom_range(0, 59) == 0);
         ra = 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
         cycle(rv, hv, ho, hf, ($urandom_range(0, 2) != 0), ra, rb);
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
